// File: rtl/l1_accum.sv
// l1_accum: per-lane accumulator behind the 4bx4b precision-scalable L1 multiplier.
// The 16-bit multiplier word is unpacked into 1, 2 or 4 unsigned lanes selected by prec.
// Each lane is summed over a window of (acc_len+1) accepted beats. The sum is then
// handed off on a valid/ready output port.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous flush of the window and the pending result (highest priority)
//   prec       00: 4x4 (1 lane), 01: 4x2 (2 lanes), 11: 2x2 (4 lanes), 10 illegal -> 00
//   acc_len    window length minus one, latched on the first beat of a window
//   in_valid   multiplier word valid
//   in_ready   block can accept a beat (low while a result is pending)
//   in_data    multiplier output word
//   out_valid  result valid
//   out_ready  consumer takes the result
//   out_prec   precision of the window that produced out_data
//   out_data   lane3..lane0, lane0 in the LSBs
module l1_accum #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [1:0]           prec,
    input  logic [CNT_W-1:0]     acc_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_prec,
    output logic [4*ACC_W-1:0]   out_data
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [1:0]              prec_q, prec_d;
    logic [3:0][ACC_W-1:0]   lane_q, lane_d;
    logic [3:0][ACC_W-1:0]   lane_inc_s, lane_sum_s;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [1:0]              out_prec_q, out_prec_d;
    logic [4*ACC_W-1:0]      out_data_q, out_data_d;
    logic                    beat_s;
    logic [1:0]              eff_prec_s;
    logic [CNT_W-1:0]        eff_len_s;

    // The illegal encoding 10 behaves as, and is reported as, 4x4.
    function automatic logic [1:0] legal_prec(input logic [1:0] p);
        return (p == 2'b10) ? 2'b00 : p;
    endfunction

    assign beat_s     = in_valid && in_ready_q;
    // On the first beat of a window the live inputs apply; afterwards the latched copies do.
    assign eff_prec_s = (cnt_q == '0) ? legal_prec(prec) : prec_q;
    assign eff_len_s  = (cnt_q == '0) ? acc_len : len_q;

    // Lane unpack (zero-extended) and per-lane adders; sums wrap modulo 2^ACC_W.
    always_comb begin
        lane_inc_s = '0;
        case (eff_prec_s)
            2'b01: begin
                lane_inc_s[1] = ACC_W'(in_data[15:8]);
                lane_inc_s[0] = ACC_W'(in_data[7:0]);
            end
            2'b11: begin
                lane_inc_s[3] = ACC_W'(in_data[15:12]);
                lane_inc_s[2] = ACC_W'(in_data[11:8]);
                lane_inc_s[1] = ACC_W'(in_data[7:4]);
                lane_inc_s[0] = ACC_W'(in_data[3:0]);
            end
            default: begin
                lane_inc_s[0] = ACC_W'(in_data);
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            lane_sum_s[i] = lane_q[i] + lane_inc_s[i];
        end
    end

    // Next-state logic for the ACC/OUT handshake FSM and the datapath registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        prec_d      = prec_q;
        lane_d      = lane_q;
        out_valid_d = out_valid_q;
        out_prec_d  = out_prec_q;
        out_data_d  = out_data_q;
        if (clr) begin
            lane_d      = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (beat_s) begin
                        prec_d = eff_prec_s;
                        len_d  = eff_len_s;
                        if (cnt_q == eff_len_s) begin
                            // Last beat: publish the sum including this beat and start afresh.
                            out_data_d  = lane_sum_s;
                            out_valid_d = 1'b1;
                            out_prec_d  = eff_prec_s;
                            lane_d      = '0;
                            cnt_d       = '0;
                            state_d     = ST_OUT;
                        end else begin
                            lane_d = lane_sum_s;
                            cnt_d  = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_ACC;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_ACC;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
        // in_ready is registered; it rises only the cycle after a handoff (no bypass).
        in_ready_d = (state_d == ST_ACC);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            len_q       <= '0;
            prec_q      <= 2'b00;
            lane_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_prec_q  <= 2'b00;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            prec_q      <= prec_d;
            lane_q      <= lane_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_prec_q  <= out_prec_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_prec  = out_prec_q;
    assign out_data  = out_data_q;

endmodule
